list_stream_cache: RTL and testbench

- Packet-to-word streaming cache for list traversal.
- Accepts fetch packets of FS words. Word 0 is a header; words 1..FS-1 are payload.
- Holds up to BS packets in a ring buffer and streams payload words out one per beat over a valid/ready interface.
- Generalises the fixed 2x4 list cache:
  - parametrised depth and width;
  - real input handshake instead of header-bit change detection;
  - backpressure-safe output, end-of-list marking and synchronous flush.

---
 rtl/list_cache_pkg.sv | 19 +
 rtl/list_stream_cache_if.sv | 25 ++
 rtl/list_slot_ring.sv | 66 ++++++
 rtl/list_stream_cache.sv | 76 +++++++
 tb/tb_list_stream_cache.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/list_cache_pkg.sv
// Shared constants, width helper and slot layout for the list stream cache.
package list_cache_pkg;

    localparam int LAST_BIT = 0;

    // $clog2 that never returns 0, so one-entry ranges still get a 1-bit pointer.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Slot layout for the default geometry (3 payload words of 32 bits).
    localparam int DEF_DW = 32;
    localparam int DEF_PW = 3;
    typedef struct packed {
        logic                           last;
        logic [DEF_PW-1:0][DEF_DW-1:0]  words;
    } slot_t;

endpackage

// File: rtl/list_stream_cache_if.sv
// Packet-in / word-out bus of the list stream cache.
// Handshake: a packet moves on i_valid && o_ready, a word moves on o_valid && i_ready,
// both at the rising edge; a producer holding valid keeps its data stable until the transfer.
interface list_stream_cache_if #(
    parameter int DW = 32,
    parameter int FS = 4,
    parameter int BS = 2
);
    localparam int CW = $clog2(BS + 1);

    logic              i_flush;
    logic [FS*DW-1:0]  IN;
    logic              i_valid;
    logic              o_ready;
    logic [DW-1:0]     OUT;
    logic              o_last;
    logic              o_valid;
    logic              i_ready;
    logic [CW-1:0]     o_count;

    modport slave  (input  i_flush, IN, i_valid, i_ready,
                    output o_ready, OUT, o_last, o_valid, o_count);
    modport master (output i_flush, IN, i_valid, i_ready,
                    input  o_ready, OUT, o_last, o_valid, o_count);
endinterface

// File: rtl/list_slot_ring.sv
// BS-slot packet ring: write/read slot pointers, occupancy count and a word-select read port.
module list_slot_ring
    import list_cache_pkg::*;
#(
    parameter int DW = 32,
    parameter int FS = 4,
    parameter int BS = 2,
    localparam int PW = FS - 1,
    localparam int SW = clog2_min1(BS),
    localparam int WW = clog2_min1(PW),
    localparam int CW = $clog2(BS + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             push,
    input  logic [PW*DW-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    input  logic [WW-1:0]    rd_wsel,
    output logic [DW-1:0]    rd_word,
    output logic             rd_last,
    output logic [CW-1:0]    count
);

    typedef struct packed {
        logic                   last;
        logic [PW-1:0][DW-1:0]  words;
    } ring_slot_t;

    ring_slot_t     mem [BS];
    logic [SW-1:0]  wr_ptr;
    logic [SW-1:0]  rd_ptr;

    // Explicit compare so non-power-of-two depths wrap at BS-1.
    function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
        return (p == SW'(BS - 1)) ? '0 : p + SW'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr].last  <= push_last;
            mem[wr_ptr].words <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_word = mem[rd_ptr].words[rd_wsel];
    assign rd_last = mem[rd_ptr].last;

endmodule

// File: rtl/list_stream_cache.sv
// Packet-to-word streaming cache: buffers packets in a slot ring and streams payload words
// through a single registered, backpressure-safe output stage.
module list_stream_cache
    import list_cache_pkg::*;
#(
    parameter int DW = 32,
    parameter int FS = 4,
    parameter int BS = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    list_stream_cache_if.slave bus
);

    localparam int PW = FS - 1;
    localparam int WW = clog2_min1(PW);
    localparam int CW = $clog2(BS + 1);

    logic [WW-1:0] wptr;
    logic [CW-1:0] count;
    logic [DW-1:0] rd_word;
    logic          rd_last;
    logic          push, pop, load, have_data, word_end;
    logic [DW-1:0] out_q;
    logic          last_q, valid_q;
    logic          unused_hdr;

    assign unused_hdr = ^bus.IN[DW-1:1];

    // Ready comes from the registered count only; a pop never frees a slot in the same cycle.
    assign bus.o_ready = !bus.i_flush && (count < CW'(BS));
    assign push        = bus.i_valid && bus.o_ready;
    assign load        = !valid_q || bus.i_ready;
    assign have_data   = (count != '0);
    assign word_end    = (wptr == WW'(PW - 1));
    assign pop         = load && have_data && word_end && !bus.i_flush;

    list_slot_ring #(.DW(DW), .FS(FS), .BS(BS)) u_ring (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear     (bus.i_flush),
        .push      (push),
        .push_data (bus.IN[FS*DW-1:DW]),
        .push_last (bus.IN[LAST_BIT]),
        .pop       (pop),
        .rd_wsel   (wptr),
        .rd_word   (rd_word),
        .rd_last   (rd_last),
        .count     (count)
    );

    always_ff @(posedge CLK) begin
        if (RESET || bus.i_flush) begin
            out_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            wptr    <= '0;
        end else if (load) begin
            if (have_data) begin
                out_q   <= rd_word;
                last_q  <= rd_last && word_end;
                valid_q <= 1'b1;
                wptr    <= word_end ? '0 : wptr + WW'(1);
            end else begin
                last_q  <= 1'b0;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.OUT     = out_q;
    assign bus.o_last  = last_q;
    assign bus.o_valid = valid_q;
    assign bus.o_count = count;

endmodule

// File: tb/tb_list_stream_cache.sv
// Bench for list_stream_cache: table-driven vectors on a 2x4 instance plus stream,
// wrap, flush and reset sequences (wrap uses a 3-slot, 5-word instance).
module tb_list_stream_cache;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  list_stream_cache_if #(.DW(32), .FS(4), .BS(2)) bus_a ();
  list_stream_cache_if #(.DW(32), .FS(5), .BS(3)) bus_b ();

  list_stream_cache #(.DW(32), .FS(4), .BS(2)) dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a.slave));
  list_stream_cache #(.DW(32), .FS(5), .BS(3)) dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        vld;
    logic [31:0] w1, w2, w3;
    logic        lst;
    logic        rdy;
    logic        e_ov;
    logic [31:0] e_out;
    logic        e_last;
    logic [31:0] e_cnt;
    logic        e_ordy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] pkt_a(input logic last, input logic [31:0] w1, w2, w3);
    return {w3, w2, w1, 31'd0, last};
  endfunction

  function automatic logic [159:0] pkt_b(input logic last, input logic [31:0] w1, w2, w3, w4);
    return {w4, w3, w2, w1, 31'd0, last};
  endfunction

  function automatic vec_t v(input logic vld, input logic [31:0] w1, w2, w3, input logic lst,
                             input logic rdy, input logic e_ov, input logic [31:0] e_out,
                             input logic e_last, input logic [31:0] e_cnt, input logic e_ordy);
    vec_t r;
    r.vld = vld; r.w1 = w1; r.w2 = w2; r.w3 = w3; r.lst = lst; r.rdy = rdy;
    r.e_ov = e_ov; r.e_out = e_out; r.e_last = e_last; r.e_cnt = e_cnt; r.e_ordy = e_ordy;
    return r;
  endfunction

  task automatic idle_inputs();
    bus_a.i_flush = 0; bus_a.i_valid = 0; bus_a.IN = '0; bus_a.i_ready = 0;
    bus_b.i_flush = 0; bus_b.i_valid = 0; bus_b.IN = '0; bus_b.i_ready = 0;
  endtask

  task automatic run_table();
    // single packet, then three packets against a two-slot ring under backpressure
    vq.push_back(v(1, 'hA, 'hB, 'hC, 1, 1,  0, 0,   0, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        1, 'hA, 0, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        1, 'hB, 0, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        1, 'hC, 1, 0, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        0, 0,   0, 0, 1));
    vq.push_back(v(1, 1, 2, 3, 0, 0,        0, 0,   0, 1, 1));
    vq.push_back(v(1, 4, 5, 6, 0, 0,        1, 1,   0, 2, 0));
    vq.push_back(v(1, 7, 8, 9, 1, 0,        1, 1,   0, 2, 0));
    vq.push_back(v(1, 7, 8, 9, 1, 0,        1, 1,   0, 2, 0));
    vq.push_back(v(1, 7, 8, 9, 1, 1,        1, 2,   0, 2, 0));
    vq.push_back(v(1, 7, 8, 9, 1, 1,        1, 3,   0, 1, 1));
    vq.push_back(v(1, 7, 8, 9, 1, 1,        1, 4,   0, 2, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        1, 5,   0, 2, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        1, 6,   0, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        1, 7,   0, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        1, 8,   0, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        1, 9,   1, 0, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1,        0, 0,   0, 0, 1));
    for (int i = 0; i < vq.size(); i++) begin
      bus_a.i_valid = vq[i].vld;
      bus_a.IN      = pkt_a(vq[i].lst, vq[i].w1, vq[i].w2, vq[i].w3);
      bus_a.i_ready = vq[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), bus_a.o_valid, vq[i].e_ov);
      if (vq[i].e_ov) begin
        chk($sformatf("vec%0d_out", i), bus_a.OUT, vq[i].e_out);
        chk($sformatf("vec%0d_last", i), bus_a.o_last, vq[i].e_last);
      end
      chk($sformatf("vec%0d_count", i), bus_a.o_count, vq[i].e_cnt);
      chk($sformatf("vec%0d_ready", i), bus_a.o_ready, vq[i].e_ordy);
    end
    bus_a.i_valid = 0;
  endtask

  task automatic run_stream_a();
    int pkt = 0;
    int cyc = 0;
    logic [31:0] w, held;
    logic held_last, acc_in, acc_out, hold;
    exp_q.delete();
    for (int i = 0; i < 24; i++) exp_q.push_back(i);
    while (exp_q.size() != 0 && cyc < 400) begin
      bus_a.i_ready = 1'($urandom_range(0, 1));
      bus_a.i_valid = (pkt < 8);
      bus_a.IN = pkt_a(pkt == 7, 3 * pkt, 3 * pkt + 1, 3 * pkt + 2);
      acc_in = bus_a.i_valid && bus_a.o_ready;
      acc_out = bus_a.o_valid && bus_a.i_ready;
      hold = bus_a.o_valid && !bus_a.i_ready;
      held = bus_a.OUT;
      held_last = bus_a.o_last;
      if (acc_out) begin
        w = exp_q.pop_front();
        chk("stream_word", held, w);
        chk("stream_last", held_last, w == 23);
      end
      tick();
      if (acc_in) pkt++;
      if (hold) chk("stream_hold", bus_a.OUT, held);
      cyc++;
    end
    chk("stream_remaining", exp_q.size(), 0);
    bus_a.i_valid = 0;
    bus_a.i_ready = 1;
    tick();
    tick();
    chk("stream_end_count", bus_a.o_count, 0);
    chk("stream_end_valid", bus_a.o_valid, 0);
  endtask

  task automatic run_wrap_b();
    int pkt = 0;
    int cyc = 0;
    logic [31:0] w, held;
    logic held_last, acc_in, acc_out, hold;
    exp_q.delete();
    for (int i = 0; i < 28; i++) exp_q.push_back(32'h100 + i);
    while (exp_q.size() != 0 && cyc < 400) begin
      bus_b.i_ready = 1'($urandom_range(0, 1));
      bus_b.i_valid = (pkt < 7);
      bus_b.IN = pkt_b(pkt == 6, 32'h100 + 4 * pkt, 32'h101 + 4 * pkt,
                       32'h102 + 4 * pkt, 32'h103 + 4 * pkt);
      acc_in = bus_b.i_valid && bus_b.o_ready;
      acc_out = bus_b.o_valid && bus_b.i_ready;
      hold = bus_b.o_valid && !bus_b.i_ready;
      held = bus_b.OUT;
      held_last = bus_b.o_last;
      if (acc_out) begin
        w = exp_q.pop_front();
        chk("wrap_word", held, w);
        chk("wrap_last", held_last, w == 32'h11b);
      end
      tick();
      if (acc_in) pkt++;
      if (hold) chk("wrap_hold", bus_b.OUT, held);
      if (bus_b.o_count > 3) chk("wrap_count_bound", bus_b.o_count, 3);
      cyc++;
    end
    chk("wrap_remaining", exp_q.size(), 0);
    chk("wrap_pkts", pkt, 7);
    bus_b.i_valid = 0;
    bus_b.i_ready = 0;
  endtask

  task automatic run_flush();
    bus_a.i_ready = 0;
    bus_a.i_valid = 1;
    bus_a.IN = pkt_a(0, 'h11, 'h12, 'h13);
    tick();
    bus_a.IN = pkt_a(0, 'h21, 'h22, 'h23);
    tick();
    bus_a.i_valid = 0;
    chk("flush_pre_count", bus_a.o_count, 2);
    chk("flush_pre_out", bus_a.OUT, 'h11);
    bus_a.i_ready = 1;
    tick();
    chk("flush_pre_out2", bus_a.OUT, 'h12);
    bus_a.i_flush = 1;
    bus_a.i_ready = 0;
    bus_a.i_valid = 1;
    bus_a.IN = pkt_a(1, 'h77, 'h78, 'h79);
    #1;
    chk("flush_cycle_ready", bus_a.o_ready, 0);
    tick();
    bus_a.i_flush = 0;
    bus_a.i_valid = 0;
    #1;
    chk("flush_valid", bus_a.o_valid, 0);
    chk("flush_count", bus_a.o_count, 0);
    chk("flush_ready", bus_a.o_ready, 1);
    bus_a.i_ready = 1;
    bus_a.i_valid = 1;
    bus_a.IN = pkt_a(1, 'h55, 'h56, 'h57);
    tick();
    bus_a.i_valid = 0;
    chk("post_flush_idle", bus_a.o_valid, 0);
    tick();
    chk("post_flush_w0", bus_a.OUT, 'h55);
    chk("post_flush_v0", bus_a.o_valid, 1);
    tick();
    chk("post_flush_w1", bus_a.OUT, 'h56);
    tick();
    chk("post_flush_w2", bus_a.OUT, 'h57);
    chk("post_flush_last", bus_a.o_last, 1);
    chk("post_flush_count", bus_a.o_count, 0);
    tick();
    chk("post_flush_drain", bus_a.o_valid, 0);
  endtask

  task automatic run_reset_mid();
    bus_a.i_ready = 0;
    bus_a.i_valid = 1;
    bus_a.IN = pkt_a(1, 'h66, 'h67, 'h68);
    tick();
    bus_a.i_valid = 0;
    tick();
    chk("rst_mid_pre_out", bus_a.OUT, 'h66);
    RESET = 1;
    tick();
    chk("rst_mid_out", bus_a.OUT, 0);
    chk("rst_mid_valid", bus_a.o_valid, 0);
    chk("rst_mid_last", bus_a.o_last, 0);
    chk("rst_mid_count", bus_a.o_count, 0);
    RESET = 0;
    bus_a.i_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid_no_stale", bus_a.o_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    RESET = 1;
    tick();
    tick();
    RESET = 0;
    chk("rst_a_valid", bus_a.o_valid, 0);
    chk("rst_a_out", bus_a.OUT, 0);
    chk("rst_a_last", bus_a.o_last, 0);
    chk("rst_a_count", bus_a.o_count, 0);
    chk("rst_a_ready", bus_a.o_ready, 1);
    chk("rst_b_valid", bus_b.o_valid, 0);
    chk("rst_b_count", bus_b.o_count, 0);
    run_table();
    run_stream_a();
    run_wrap_b();
    run_flush();
    run_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
